fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/execute path that feeds branch_jump_unit with PC and instruction.
- Generates sequential PCs and issues word requests to instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Consumes the branch/jump redirect (taken, target, flush): discards wrong-path instructions and restarts fetch at the target.

---
 rtl/riscv_defs_pkg.sv | 19 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared fetch-path definitions: reset vector, fetch entry record, fetch FSM states.
// S_HALT exists only when FETCH_MISALIGN_TRAP_EN is defined.
package riscv_defs_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instruction;
   } fetch_entry_t;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_t;
`else
   typedef enum logic [1:0] {S_BOOT, S_RUN} fetch_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head, synchronous clear and occupancy count.
// Used as the instruction buffer and as the in-order pending-PC queue of the fetch unit.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop & !empty;
   // a push into a full buffer is fine when the head leaves in the same cycle
   assign do_push  = push & (!full | do_pop);
   assign data_out = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests, buffered hand-off to decode.
// Optional FETCH_MISALIGN_TRAP_EN adds o_misaligned and halts fetch on a misaligned redirect target.
//
// state  | meaning
// S_BOOT | one idle cycle after reset, no request
// S_RUN  | normal fetch
// S_HALT | misaligned redirect seen, fetch stopped (FETCH_MISALIGN_TRAP_EN only)
module fetch_unit
   import riscv_defs_pkg::*;
#(
   parameter int                 NB_WORD    = 32,
   parameter int                 NB_ADDR    = 32,
   parameter logic [NB_ADDR-1:0] RESET_ADDR = NB_ADDR'(RESET_VECTOR),
   parameter int                 FIFO_DEPTH = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   output logic               o_imem_req,
   output logic [NB_ADDR-1:0] o_imem_addr,
   input  logic               i_imem_gnt,
   input  logic               i_imem_rvalid,
   input  logic [NB_WORD-1:0] i_imem_rdata,
   input  logic               i_branch_taken,
   input  logic [NB_ADDR-1:0] i_branch_addr,
   input  logic               i_flush,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NB_ADDR-1:0] o_pc,
   output logic [NB_WORD-1:0] o_instruction
`ifdef FETCH_MISALIGN_TRAP_EN
   ,output logic              o_misaligned
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = NB_ADDR + NB_WORD;

   fetch_state_t       state;
   fetch_state_t       state_next;
   logic [NB_ADDR-1:0] fetch_pc;
   logic [NB_ADDR-1:0] pend_pc;
   logic [NB_ADDR-1:0] target;
   logic [CW-1:0]      buf_count;
   logic [CW-1:0]      pend_count;
   logic [CW-1:0]      drop_cnt;
   logic [CW:0]        occupancy;
   logic [EW-1:0]      buf_out;
   logic               redirect;
   logic               pop;
   logic               fire;
   logic               resp_keep;

   assign redirect  = i_flush & i_branch_taken;
   assign target    = i_branch_addr & ~NB_ADDR'(3);
   assign pop       = o_valid & i_ready & !i_flush;
   assign fire      = o_imem_req & i_imem_gnt;
   assign resp_keep = i_imem_rvalid & (drop_cnt == '0) & !i_flush;

   // the pending queue holds exactly the outstanding requests, so its count is the outstanding counter;
   // a slot vacated by this cycle's pop counts as free so a 1-cycle memory sustains one instruction per cycle
   assign occupancy = (CW+1)'(buf_count) + (CW+1)'(pend_count) - (CW+1)'(pop);

   assign o_imem_addr   = fetch_pc;
   assign o_valid       = (buf_count != '0);
   assign o_pc          = buf_out[NB_WORD +: NB_ADDR];
   assign o_instruction = buf_out[NB_WORD-1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned_redirect;
   assign misaligned_redirect = redirect & (i_branch_addr[1:0] != 2'b00);
`endif

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) state <= S_BOOT;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_BOOT: state_next = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
         S_HALT: if (redirect) state_next = S_RUN;
`endif
         default: state_next = state;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned_redirect) state_next = S_HALT;
`endif
   end

   always_comb begin
      o_imem_req = (state == S_RUN) & !i_flush & (occupancy < (CW+1)'(FIFO_DEPTH));
`ifdef FETCH_MISALIGN_TRAP_EN
      o_misaligned = (state == S_HALT);
`endif
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         fetch_pc <= RESET_ADDR;
         drop_cnt <= '0;
      end else if (i_flush) begin
         if (i_branch_taken) fetch_pc <= target;
         // a response arriving in the flush cycle is already discarded, so it is not counted again
         drop_cnt <= pend_count - CW'(i_imem_rvalid);
      end else begin
         if (fire) fetch_pc <= fetch_pc + NB_ADDR'(4);
         if (i_imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
   end

   sync_fifo #(.WIDTH(NB_ADDR), .DEPTH(FIFO_DEPTH), .CW(CW)) u_pending (
      .clk      (i_clock),
      .rst      (i_reset),
      .clear    (1'b0),
      .push     (fire),
      .pop      (i_imem_rvalid),
      .data_in  (fetch_pc),
      .data_out (pend_pc),
      .count    (pend_count)
   );

   sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_ibuf (
      .clk      (i_clock),
      .rst      (i_reset),
      .clear    (i_flush),
      .push     (resp_keep),
      .pop      (pop),
      .data_in  ({pend_pc, i_imem_rdata}),
      .data_out (buf_out),
      .count    (buf_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with random in-order latency, expected stream of (pc, instr).
// Exercises the trap path when FETCH_MISALIGN_TRAP_EN is defined.
module tb_fetch_unit;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_branch_taken;
   logic [31:0] i_branch_addr;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        o_misaligned;
`endif

   fetch_unit #(.NB_WORD(32), .NB_ADDR(32), .RESET_ADDR(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .o_imem_req     (o_imem_req),
      .o_imem_addr    (o_imem_addr),
      .i_imem_gnt     (i_imem_gnt),
      .i_imem_rvalid  (i_imem_rvalid),
      .i_imem_rdata   (i_imem_rdata),
      .i_branch_taken (i_branch_taken),
      .i_branch_addr  (i_branch_addr),
      .i_flush        (i_flush),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_pc           (o_pc),
      .o_instruction  (o_instruction)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,.o_misaligned  (o_misaligned)
`endif
   );

   always #5 i_clock = ~i_clock;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic [31:0] addr; int due; } mem_t;

   exp_t        sb_q[$];
   mem_t        mem_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          pops = 0;
   logic [31:0] exp_fetch;
   bit          last_valid;
   bit          last_req;
   bit          saw_zero;
   bit          prev_flush = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: every accepted instruction must be the oldest expected right-path entry
   always @(negedge i_clock) begin : monitor
      exp_t e;
      #1;
      if (i_reset) prev_flush = 1'b0;
      else begin
         if (prev_flush) check_bit("valid_after_flush", o_valid, 1'b0);
         if (!i_flush && o_valid) begin
            if (sb_q.size() == 0) check_bit("spurious_valid", o_valid, 1'b0);
            else if (i_ready) begin
               e = sb_q.pop_front();
               pops++;
               check("pop_pc", o_pc, e.pc);
               check("pop_instr", o_instruction, e.instr);
            end else check("stall_head_pc", o_pc, sb_q[0].pc);
         end
         prev_flush = i_flush;
      end
   end

   // one clock cycle: entered and left just after a rising edge
   task automatic step(input bit rdy, input bit gnt, input bit fl, input bit tk,
                       input logic [31:0] tgt, input int lat);
      mem_t m;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         m             = mem_q.pop_front();
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mem_word(m.addr);
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = $urandom;
      end
      i_ready        = rdy;
      i_imem_gnt     = gnt;
      i_flush        = fl;
      i_branch_taken = tk;
      i_branch_addr  = tgt;
      @(negedge i_clock);
      last_valid = o_valid;
      last_req   = o_imem_req;
      check_bit("inflight_bound", (mem_q.size() + int'(i_imem_rvalid)) <= DEPTH, 1'b1);
      if (fl) begin
         check_bit("no_req_on_flush", o_imem_req, 1'b0);
         if (tk) exp_fetch = tgt & ~32'h3;
         sb_q.delete();
      end else if (o_imem_req && gnt) begin
         check("req_addr", o_imem_addr, exp_fetch);
         if (exp_fetch == 32'h0) saw_zero = 1'b1;
         sb_q.push_back('{exp_fetch, mem_word(exp_fetch)});
         m.addr   = o_imem_addr;
         m.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         last_due = m.due;
         mem_q.push_back(m);
         exp_fetch = exp_fetch + 32'd4;
      end
      @(posedge i_clock);
      #1;
   endtask

   task automatic do_reset();
      i_reset        = 1'b1;
      i_imem_gnt     = 1'b0;
      i_imem_rvalid  = 1'b0;
      i_imem_rdata   = '0;
      i_flush        = 1'b0;
      i_branch_taken = 1'b0;
      i_branch_addr  = '0;
      i_ready        = 1'b0;
      #1;
      check_bit("rst_req", o_imem_req, 1'b0);
      check_bit("rst_valid", o_valid, 1'b0);
      check("rst_pc", o_pc, 32'h0);
      check("rst_instr", o_instruction, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check_bit("rst_misaligned", o_misaligned, 1'b0);
`endif
      sb_q.delete();
      mem_q.delete();
      exp_fetch = RST_PC;
      last_due  = cyc;
      repeat (2) @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      @(negedge i_clock);
      check_bit("boot_no_req", o_imem_req, 1'b0);
      @(posedge i_clock);
      #1;
   endtask

   initial begin
      int bubbles;
      int pops_before;
      bit seen;
      bit rdy, gnt, fl, tk;
      logic [31:0] tgt;

      i_reset        = 1'b0;
      i_imem_gnt     = 1'b0;
      i_imem_rvalid  = 1'b0;
      i_imem_rdata   = '0;
      i_flush        = 1'b0;
      i_branch_taken = 1'b0;
      i_branch_addr  = '0;
      i_ready        = 1'b0;
      exp_fetch      = RST_PC;
      #1;
      do_reset();

      // streaming with 1-cycle memory: no bubbles once the first instruction arrives
      bubbles = 0;
      seen    = 1'b0;
      for (int i = 0; i < 24; i++) begin
         step(1, 1, 0, 0, 32'h0, 1);
         if (last_valid) seen = 1'b1;
         else if (seen) bubbles++;
      end
      check_bit("stream_started", seen, 1'b1);
      check("stream_bubbles", 32'(bubbles), 32'h0);

      // decode stall: head held, issue throttled
      repeat (6) step(0, 1, 0, 0, 32'h0, 1);
      check_bit("stall_req_blocked", last_req, 1'b0);
      check_bit("stall_valid_held", last_valid, 1'b1);
      repeat (6) step(1, 1, 0, 0, 32'h0, 1);

      // redirect with slow memory so responses are in flight
      repeat (6) step(1, 1, 0, 0, 32'h0, 3);
      step(1, 1, 1, 1, 32'h0000_0100, 3);
      repeat (12) step(1, 1, 0, 0, 32'h0, 3);

      // redirect coinciding with a returning response
      repeat (5) step(1, 1, 0, 0, 32'h0, 1);
      step(1, 1, 1, 1, 32'h0000_0040, 1);
      repeat (8) step(1, 1, 0, 0, 32'h0, 1);

`ifndef FETCH_MISALIGN_TRAP_EN
      step(1, 1, 1, 1, 32'h0000_0203, 1);
      repeat (6) step(1, 1, 0, 0, 32'h0, 1);
`endif

      // PC wrap
      saw_zero = 1'b0;
      step(1, 1, 1, 1, 32'hFFFF_FFF8, 1);
      repeat (8) step(1, 1, 0, 0, 32'h0, 1);
      check_bit("pc_wrap", saw_zero, 1'b1);

      // flush without redirect
      repeat (3) step(1, 1, 0, 0, 32'h0, 2);
      step(1, 1, 1, 0, 32'h5555_0000, 2);
      repeat (8) step(1, 1, 0, 0, 32'h0, 2);

      // randomized traffic with one mid-run reset
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         rdy = ($urandom_range(0, 3) != 0);
         gnt = ($urandom_range(0, 2) != 0);
         fl  = ($urandom_range(0, 24) == 0);
         tk  = ($urandom_range(0, 4) != 0);
         tgt = $urandom & 32'h000F_FFFF;
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt = tgt & ~32'h3;
`endif
         step(rdy, gnt, fl, tk, tgt, int'($urandom_range(1, 3)));
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      repeat (4) step(1, 1, 0, 0, 32'h0, 1);
      step(1, 1, 1, 1, 32'h0000_0102, 1);
      check_bit("trap_set", o_misaligned, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, 0, 32'h0, 1);
         check_bit("trap_no_req", last_req, 1'b0);
      end
      step(1, 1, 1, 1, 32'h0000_0200, 1);
      check_bit("trap_cleared", o_misaligned, 1'b0);
      pops_before = pops;
      repeat (8) step(1, 1, 0, 0, 32'h0, 1);
      check_bit("trap_resumed", pops > pops_before, 1'b1);
`else
      pops_before = pops;
      repeat (8) step(1, 1, 0, 0, 32'h0, 1);
      check_bit("final_delivery", pops > pops_before, 1'b1);
`endif

      repeat (6) step(1, 1, 0, 0, 32'h0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
